act_skew_feeder: RTL and testbench
==================================

Name: act_skew_feeder

Overview:
- Upstream stage of the weight-stationary PE array. Accepts one activation vector of ARRAY_SIZE lanes per handshake and feeds it to the array rows.
- Skews lane i by i cycles, forming the diagonal wavefront the array needs.
- Drives the array-wide compute enable and flushes the array with zeros after the last vector.
- Inserts zero bubbles when upstream stalls and tags every lane with a valid bit, so downstream can discard bubble results.

Parameters:
- ARRAY_SIZE, 4, number of array rows/lanes (>=2)
- COMPUTE_DATA_WIDTH, 4, signed activation width per lane
- LEN_WIDTH, 8, width of the vector-count command

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle command pulse; sampled in IDLE only
- num_vecs  in  LEN_WIDTH  vectors to stream; sampled with start
- in_valid  in  1  upstream vector valid
- in_ready  out  1  feeder accepts vector this cycle
- in_data  in  ARRAY_SIZE*COMPUTE_DATA_WIDTH  lane i at bits [i*W +: W]
- out_data  out  ARRAY_SIZE*COMPUTE_DATA_WIDTH  skewed lanes to array row inputs
- out_lane_valid  out  ARRAY_SIZE  bit i set when out_data lane i carries real data
- compute  out  1  array compute enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of job
- bubble_count  out  16  stall bubbles inserted (see Optional Feature)

Behaviour:
- Reset: all outputs 0, all skew registers 0, state IDLE. A reset asserted mid-job aborts it:
  - no done pulse;
  - next cycle all outputs are 0.
- States:
  - IDLE:
    - in_ready=0, compute=0.
    - start && num_vecs!=0 -> FEED; load remaining=num_vecs.
    - start && num_vecs==0 -> done=1 next cycle, stay IDLE.
  - FEED:
    - in_ready=1.
    - Every cycle one vector enters the skew line:
      - if in_valid: in_data with valid=1 (accepted); remaining decrements;
      - else: zero vector with valid=0 (bubble).
    - Accepting the last vector (remaining==1 && in_valid) -> DRAIN; load drain counter=2*ARRAY_SIZE-1.
  - DRAIN:
    - in_ready=0; zero vectors with valid=0 enter.
    - Counter decrements each cycle; at 1 -> DONE.
  - DONE: done=1 for exactly one cycle, compute=0, -> IDLE.
- Skew:
  - Lane i is delayed through i+1 registers, so lane 0 appears 1 cycle after acceptance and lane i appears i+1 cycles after.
  - The valid bit travels with its lane data in the same register chain.
- compute:
  - Registered.
  - 1 in the cycle any lane's out_data carries a FEED- or DRAIN-sourced entry, i.e. from 1 cycle after entering FEED through the cycle the last drain entry exits lane ARRAY_SIZE-1.
  - 0 otherwise.
- Skew chain contents:
  - Cleared to zero on reset only.
  - Not cleared on start, because the previous job has fully drained before IDLE.
- start while busy: ignored, no effect on counters.
- in_valid while in_ready=0: ignored; data not consumed.
- Data is passed through unmodified; no arithmetic.
- busy: registered, equals (state!=IDLE).

Optional Feature:
- Macro FEEDER_PERF_CNT_EN.
- Defined:
  - bubble_count increments on each FEED cycle with in_valid=0;
  - saturates at 16'hFFFF;
  - cleared to 0 on the accepted start (and on rst);
  - holds its value after done.
- Undefined: bubble_count is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset mid-job: rst asserted for 1 cycle during FEED -> next cycle state IDLE, all outputs 0, no done pulse, and a subsequent start runs normally.
- Back-to-back stream:
  - ARRAY_SIZE=4, start num_vecs=3, in_valid held high, vectors {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4} (lane0..3).
  - Lane0 shows 1,5,-1 on cycles t+1..t+3; lane3 shows 4,8,-4 on t+4..t+6.
  - out_lane_valid matches; done pulses once after 7 drain cycles.
- Stall bubble:
  - num_vecs=2, in_valid low for 2 cycles between vectors.
  - Two zero entries with out_lane_valid=0 appear on each lane between the real vectors.
  - bubble_count=2 with FEEDER_PERF_CNT_EN; 0 without.
- Zero length: start with num_vecs=0 -> done=1 on the next cycle, busy and compute stay 0, in_ready stays 0.
- Start while busy: a second start with num_vecs=5 during FEED is ignored; exactly the original count is accepted and one done pulse is produced.

Source files
------------

// File: rtl/act_skew_feeder.sv
// Purpose: feeds activation vectors to the PE array rows as a diagonal wavefront (lane i skewed by i cycles).
// Latency: lane i of an accepted vector reaches out_data i+1 cycles after acceptance.
// Backpressure: in_ready high only in FEED; upstream stalls insert zero bubbles tagged invalid.
// Optional: FEEDER_PERF_CNT_EN builds the saturating stall-bubble counter behind bubble_count.
module act_skew_feeder #(
    parameter int ARRAY_SIZE         = 4,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int LEN_WIDTH          = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [LEN_WIDTH-1:0]                     num_vecs,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0] in_data,
    output logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0] out_data,
    output logic [ARRAY_SIZE-1:0]                    out_lane_valid,
    output logic                                     compute,
    output logic                                     busy,
    output logic                                     done,
    output logic [15:0]                              bubble_count
);

    localparam int W         = COMPUTE_DATA_WIDTH;
    localparam int A         = ARRAY_SIZE;
    localparam int DRAIN_LEN = 2 * A - 1;
    localparam int DCNT_W    = $clog2(2 * A);
    localparam int TAG_W     = A - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // One skew-line slot: the valid bit rides with its lane data.
    typedef struct packed {
        logic         vld;
        logic [W-1:0] dat;
    } lane_t;

    state_t               state_q;
    state_t               state_d;
    logic [LEN_WIDTH-1:0] rem_q;
    logic [LEN_WIDTH-1:0] rem_d;
    logic [DCNT_W-1:0]    drain_q;
    logic [DCNT_W-1:0]    drain_d;
    logic                 done_d;
    logic                 start_acc;
    logic                 feed_cycle;
    logic                 vec_acc;
    logic                 src_now;
    logic [TAG_W-1:0]     src_tag_q;
    logic [A-1:0]         lane_vld;

    assign start_acc  = (state_q == S_IDLE) && start;
    assign feed_cycle = (state_q == S_FEED);
    assign vec_acc    = feed_cycle && in_valid;
    // Every FEED or DRAIN cycle pushes one entry (real or zero) into the skew line.
    assign src_now    = feed_cycle || (state_q == S_DRAIN);

    // Next-state, vector/drain counters and the done request.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_vecs != '0) begin
                        state_d = S_FEED;
                        rem_d   = num_vecs;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FEED: begin
                if (in_valid) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                        drain_d = DCNT_W'(DRAIN_LEN);
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q - DCNT_W'(1);
                if (drain_q == DCNT_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered control outputs; compute covers the skew depth after the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            drain_q   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            compute   <= 1'b0;
            src_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            drain_q   <= drain_d;
            done      <= done_d;
            busy      <= (state_d != S_IDLE);
            in_ready  <= (state_d == S_FEED);
            compute   <= src_now | (|src_tag_q);
            src_tag_q <= TAG_W'({src_tag_q, src_now});
        end
    end

    for (genvar i = 0; i < A; i++) begin : g_lane
        lane_t stage_q [i+1];
        lane_t entry;

        assign entry.vld = vec_acc;
        assign entry.dat = vec_acc ? in_data[i*W +: W] : '0;

        // Lane i shift chain of i+1 slots; contents only cleared by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    stage_q[j] <= '0;
                end
            end else begin
                stage_q[0] <= entry;
                for (int j = 1; j <= i; j++) begin
                    stage_q[j] <= stage_q[j-1];
                end
            end
        end

        assign out_data[i*W +: W] = stage_q[i].dat;
        assign lane_vld[i]        = stage_q[i].vld;
    end

    assign out_lane_valid = lane_vld;

`ifdef FEEDER_PERF_CNT_EN
    logic [15:0] bub_q;

    // Count FEED cycles without upstream data; saturate, clear on a new job.
    always_ff @(posedge clk) begin
        if (rst) begin
            bub_q <= '0;
        end else if (start_acc) begin
            bub_q <= '0;
        end else if (feed_cycle && !in_valid && (bub_q != 16'hFFFF)) begin
            bub_q <= bub_q + 16'd1;
        end
    end

    assign bubble_count = bub_q;
`else
    assign bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Purpose: randomized + directed scoreboard bench for act_skew_feeder.
// Latency: expectations stamped with the cycle each lane entry / done pulse must appear.
// Backpressure: driver inserts upstream stalls and drives junk while in_ready is low.
module tb_act_skew_feeder;

    localparam int A    = 4;
    localparam int W    = 4;
    localparam int LW   = 8;
    localparam int MAXC = 8192;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [LW-1:0]   num_vecs;
    logic            in_valid;
    logic            in_ready;
    logic [A*W-1:0]  in_data;
    logic [A*W-1:0]  out_data;
    logic [A-1:0]    out_lane_valid;
    logic            compute;
    logic            busy;
    logic            done;
    logic [15:0]     bubble_count;

    act_skew_feeder #(.ARRAY_SIZE(A), .COMPUTE_DATA_WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_data(out_data), .out_lane_valid(out_lane_valid), .compute(compute),
        .busy(busy), .done(done), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] dat;
        int           t;
    } lane_exp_t;

    lane_exp_t lane_q [A][$];
    int        done_q [$];
    bit        exp_busy  [MAXC];
    bit        exp_ready [MAXC];
    byte       exp_comp  [MAXC];   // 0 low, 1 high, 2 not compared
    int        bc_model;
    bit        mon_en = 1'b0;
    int        checks = 0;
    int        errors = 0;
    int        dir_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, -1, -2, -3, -4};

    function automatic void mark_comp(input int t, input int v);
        if (t < MAXC) begin
            if (v == 1) exp_comp[t] = 1;
            else if (exp_comp[t] == 0) exp_comp[t] = 2;
        end
    endfunction

    task automatic check_bc(input string name);
        int expv;
`ifdef FEEDER_PERF_CNT_EN
        expv = bc_model;
`else
        expv = 0;
`endif
        checks++;
        if (int'(bubble_count) != expv) begin
            errors++;
            $display("FAIL %s bubble_count got=%0d required=%0d", name, bubble_count, expv);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin : mon
        logic [W-1:0] d;
        lane_exp_t    e;
        if (mon_en) begin
            for (int i = 0; i < A; i++) begin
                d = out_data[i*W +: W];
                checks++;
                if (out_lane_valid[i]) begin
                    if (lane_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d_unexpected cyc=%0d got=%0d required=no valid", i, cyc, d);
                    end else begin
                        e = lane_q[i].pop_front();
                        if (e.t != cyc || e.dat !== d) begin
                            errors++;
                            $display("FAIL lane%0d_data cyc=%0d got=%0d required=%0d at cyc %0d", i, cyc, d, e.dat, e.t);
                        end
                    end
                end else begin
                    if (d !== '0) begin
                        errors++;
                        $display("FAIL lane%0d_bubble cyc=%0d got=%0d required=0", i, cyc, d);
                    end
                    if (lane_q[i].size() != 0 && lane_q[i][0].t <= cyc) begin
                        e = lane_q[i].pop_front();
                        errors++;
                        $display("FAIL lane%0d_missing cyc=%0d got=invalid required=%0d", i, cyc, e.dat);
                    end
                end
            end
            checks++;
            if (busy !== exp_busy[cyc]) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, exp_busy[cyc]);
            end
            checks++;
            if (in_ready !== exp_ready[cyc]) begin
                errors++;
                $display("FAIL in_ready cyc=%0d got=%b required=%b", cyc, in_ready, exp_ready[cyc]);
            end
            if (exp_comp[cyc] != 2) begin
                checks++;
                if (compute !== (exp_comp[cyc] == 1)) begin
                    errors++;
                    $display("FAIL compute cyc=%0d got=%b required=%0d", cyc, compute, exp_comp[cyc]);
                end
            end
            checks++;
            if (done === 1'b1) begin
                if (done_q.size() != 0 && done_q[0] == cyc) begin
                    void'(done_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d got=1 required=0", cyc);
                end
            end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
                void'(done_q.pop_front());
                errors++;
                $display("FAIL done_missing cyc=%0d got=%b required=1", cyc, done);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            start    = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = (A*W)'($urandom);
        end
        in_valid = 1'b0;
    endtask

    // mode: 0 no stalls, 1 two stalls between vectors, 2 random 0..2 stalls.
    task automatic run_job(input int n, input int mode, input bit dir,
                           input bit extra_start, input int rst_after);
        int s, k, c, acc, stall, fed;
        lane_exp_t e;
        s        = cyc;
        start    = 1'b1;
        num_vecs = LW'(n);
        in_valid = 1'b0;
        bc_model = 0;
        if (n == 0) begin
            done_q.push_back(s + 1);
            idle(3);
            check_bc("zero_len");
            return;
        end
        acc = 0; stall = 0; fed = 0; k = s;
        while (acc < n) begin
            next_cycle();
            k        = cyc;
            start    = 1'b0;
            exp_busy[k]  = 1'b1;
            exp_ready[k] = 1'b1;
            for (int j = 1; j <= A; j++) mark_comp(k + j, 1);
            if (extra_start && fed == 1) begin
                start    = 1'b1;
                num_vecs = LW'(5);
            end
            fed++;
            if (rst_after >= 0 && acc == rst_after) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                next_cycle();
                rst = 1'b0;
                for (int i = 0; i < A; i++) lane_q[i].delete();
                done_q.delete();
                for (int t = cyc; t < cyc + 64 && t < MAXC; t++) begin
                    exp_busy[t] = 1'b0; exp_ready[t] = 1'b0; exp_comp[t] = 0;
                end
                bc_model = 0;
                check_bc("after_reset");
                idle(1);
                return;
            end
            if (stall > 0) begin
                in_valid = 1'b0;
                in_data  = (A*W)'($urandom);
                bc_model++;
                stall--;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < A; i++) begin
                    if (dir) in_data[i*W +: W] = W'(dir_tab[acc*A + i]);
                    else     in_data[i*W +: W] = W'($urandom);
                    e.dat = in_data[i*W +: W];
                    e.t   = k + 1 + i;
                    lane_q[i].push_back(e);
                end
                acc++;
                stall = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            end
        end
        c = k;
        for (int t = c + 1; t <= c + 2*A; t++) exp_busy[t] = 1'b1;
        for (int dk = c + 1; dk <= c + 2*A - 1; dk++)
            for (int j = 1; j <= A; j++)
                mark_comp(dk + j, (dk + j <= c + 2*A - 1) ? 1 : 2);
        done_q.push_back(c + 2*A);
        while (cyc < c + 2*A) begin
            next_cycle();
            start    = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = (A*W)'($urandom);
        end
        in_valid = 1'b0;
        next_cycle();
        check_bc("job_end");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_vecs = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        checks++;
        if ({out_data, out_lane_valid, compute, busy, done, in_ready, bubble_count} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h/%b/%b%b%b%b/%0d required=all zero",
                     out_data, out_lane_valid, compute, busy, done, in_ready, bubble_count);
        end
        bc_model = 0;
        check_bc("reset");
        idle(2);
        run_job(3, 0, 1'b1, 1'b0, -1);     // back-to-back directed stream
        idle(2);
        run_job(2, 1, 1'b0, 1'b0, -1);     // two-cycle stall between vectors
        run_job(0, 0, 1'b0, 1'b0, -1);     // zero length
        run_job(3, 0, 1'b0, 1'b1, -1);     // start while busy is ignored
        idle(1);
        run_job(4, 2, 1'b0, 1'b0, 2);      // reset mid-job
        run_job(3, 0, 1'b0, 1'b0, -1);     // normal job after abort
        for (int r = 0; r < 20; r++) begin
            run_job($urandom_range(1, 8), 2, 1'b0, 1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 3));
        end
        idle(3*A + 4);
        for (int i = 0; i < A; i++) begin
            checks++;
            if (lane_q[i].size() != 0) begin
                errors++;
                $display("FAIL lane%0d_leftover got=%0d entries required=0", i, lane_q[i].size());
            end
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_leftover got=%0d pending required=0", done_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
